// File: rtl/cnn_layer_accel_weight_cfg_loader.sv
// Weight configuration loader: streams 3x3 kernel weights from a valid/ready source into the
// CE weight table's configuration port, framing each load with job_accept/config_mode/job_done.
module cnn_layer_accel_weight_cfg_loader #(
   parameter int unsigned C_KERNEL_WORDS         = 9,
   parameter int unsigned C_MAX_BRAM_3X3_KERNELS = 16,
   parameter int unsigned C_CLG2_MAX_KERNELS     = $clog2(C_MAX_BRAM_3X3_KERNELS)
) (
   input  logic                          clk_core,
   input  logic                          rst,
   input  logic                          job_start,
   input  logic [C_CLG2_MAX_KERNELS-1:0] num_kernels,
   input  logic                          abort,
   input  logic                          wht_in_valid,
   input  logic [15:0]                   wht_in_data,
   output logic                          wht_in_ready,
   output logic                          job_accept,
   output logic                          config_mode,
   output logic                          wht_config_wren,
   output logic [15:0]                   wht_config_data,
   output logic                          job_busy,
   output logic                          job_done
);

   localparam int unsigned WordCntW = (C_KERNEL_WORDS > 1) ? $clog2(C_KERNEL_WORDS) : 1;
   localparam logic [WordCntW-1:0] LastWord = WordCntW'(C_KERNEL_WORDS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StAccept,
      StLoad,
      StDrain,
      StDone
   } state_e;

   state_e                          state_q, state_d;
   logic [WordCntW-1:0]             word_cnt_q, word_cnt_d;
   logic [C_CLG2_MAX_KERNELS-1:0]   kern_cnt_q, kern_cnt_d;
   logic [C_CLG2_MAX_KERNELS-1:0]   last_k_q, last_k_d;
   logic                            job_accept_q, job_accept_d;
   logic                            config_mode_q, config_mode_d;
   logic                            wren_q, wren_d;
   logic [15:0]                     data_q, data_d;
   logic                            job_busy_q, job_busy_d;
   logic                            job_done_q, job_done_d;

   logic handshake;
   logic write_ok;

   assign wht_in_ready = (state_q == StLoad);
   assign handshake    = wht_in_ready && wht_in_valid;
   // An abort in the same cycle as a handshake drops that word.
   assign write_ok     = handshake && !abort;

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      kern_cnt_d = kern_cnt_q;
      last_k_d   = last_k_q;

      unique case (state_q)
         StIdle: begin
            if (job_start) begin
               state_d    = StAccept;
               last_k_d   = num_kernels;
               word_cnt_d = '0;
               kern_cnt_d = '0;
            end
         end
         StAccept: state_d = StLoad;
         StLoad: begin
            if (handshake) begin
               if (word_cnt_q == LastWord) begin
                  word_cnt_d = '0;
                  // Final kernel: hold kern_cnt at last_k so it can never overflow.
                  if (kern_cnt_q == last_k_q) begin
                     state_d = StDrain;
                  end else begin
                     kern_cnt_d = kern_cnt_q + 1'b1;
                  end
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end
         end
         StDrain: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_comb begin
      job_accept_d  = (state_d == StAccept);
      config_mode_d = (state_d == StAccept) || (state_d == StLoad) || (state_d == StDrain);
      job_busy_d    = (state_d != StIdle);
      job_done_d    = (state_d == StDone);
      wren_d        = write_ok;
      data_d        = write_ok ? wht_in_data : data_q;
   end

   always_ff @(posedge clk_core) begin
      if (rst) begin
         state_q       <= StIdle;
         word_cnt_q    <= '0;
         kern_cnt_q    <= '0;
         last_k_q      <= '0;
         job_accept_q  <= 1'b0;
         config_mode_q <= 1'b0;
         wren_q        <= 1'b0;
         data_q        <= 16'h0000;
         job_busy_q    <= 1'b0;
         job_done_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_cnt_q    <= word_cnt_d;
         kern_cnt_q    <= kern_cnt_d;
         last_k_q      <= last_k_d;
         job_accept_q  <= job_accept_d;
         config_mode_q <= config_mode_d;
         wren_q        <= wren_d;
         data_q        <= data_d;
         job_busy_q    <= job_busy_d;
         job_done_q    <= job_done_d;
      end
   end

   assign job_accept      = job_accept_q;
   assign config_mode     = config_mode_q;
   assign wht_config_wren = wren_q;
   assign wht_config_data = data_q;
   assign job_busy        = job_busy_q;
   assign job_done        = job_done_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_cfg_loader.sv
// Directed bench for the weight configuration loader: timing, backpressure, max load,
// ignored restart, abort and mid-load reset.
module tb_cnn_layer_accel_weight_cfg_loader;

   logic        clk_core = 1'b0;
   logic        rst;
   logic        job_start;
   logic [3:0]  num_kernels;
   logic        abort;
   logic        wht_in_valid;
   logic [15:0] wht_in_data;
   logic        wht_in_ready;
   logic        job_accept;
   logic        config_mode;
   logic        wht_config_wren;
   logic [15:0] wht_config_data;
   logic        job_busy;
   logic        job_done;

   cnn_layer_accel_weight_cfg_loader #(
      .C_KERNEL_WORDS         (9),
      .C_MAX_BRAM_3X3_KERNELS (16),
      .C_CLG2_MAX_KERNELS     (4)
   ) dut (
      .clk_core        (clk_core),
      .rst             (rst),
      .job_start       (job_start),
      .num_kernels     (num_kernels),
      .abort           (abort),
      .wht_in_valid    (wht_in_valid),
      .wht_in_data     (wht_in_data),
      .wht_in_ready    (wht_in_ready),
      .job_accept      (job_accept),
      .config_mode     (config_mode),
      .wht_config_wren (wht_config_wren),
      .wht_config_data (wht_config_data),
      .job_busy        (job_busy),
      .job_done        (job_done)
   );

   always #5 clk_core = ~clk_core;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int t0       = 0;
   int last_hs  = -1;
   int ready_drop;
   logic [15:0] wr_q[$];
   int n_acc, n_done, n_cm, acc_cyc, done_cyc, first_wr, last_wr, cm_first, cm_last, busy_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_stats();
      wr_q.delete();
      n_acc = 0; n_done = 0; n_cm = 0;
      acc_cyc = -1; done_cyc = -1; first_wr = -1; last_wr = -1;
      cm_first = -1; cm_last = -1; busy_last = -1;
   endtask

   // Advance one clock and record what the DUT shows in the new cycle.
   task automatic tick();
      @(posedge clk_core);
      #1;
      cyc++;
      if (wht_config_wren) begin
         wr_q.push_back(wht_config_data);
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
      end
      if (job_accept) begin n_acc++; acc_cyc = cyc; end
      if (job_done) begin n_done++; done_cyc = cyc; end
      if (config_mode) begin
         n_cm++;
         if (cm_first < 0) cm_first = cyc;
         cm_last = cyc;
      end
      if (job_busy) busy_last = cyc;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start_job(input logic [3:0] nk, input logic ab);
      job_start   = 1'b1;
      num_kernels = nk;
      abort       = ab;
      t0          = cyc;
      tick();
      job_start   = 1'b0;
      abort       = 1'b0;
      num_kernels = 4'd3;
   endtask

   // Offer n words base, base+1, ...; optional 1,0,1,0 valid pattern and a stray job_start.
   task automatic feed(input int n, input logic [15:0] base, input bit stall, input int poke);
      int  idx = 0;
      int  k   = 0;
      bit  seen_rdy = 0;
      ready_drop = 0;
      while (idx < n && k < 2000) begin
         wht_in_valid = stall ? ((k % 2) == 0) : 1'b1;
         wht_in_data  = base + 16'(idx);
         job_start    = (cyc == poke);
         if (wht_in_ready) seen_rdy = 1;
         else if (seen_rdy) ready_drop++;
         if (wht_in_ready && wht_in_valid) begin
            idx++;
            last_hs = cyc;
         end
         tick();
         k++;
      end
      wht_in_valid = 1'b0;
      job_start    = 1'b0;
   endtask

   task automatic check_data(input string tag, input logic [15:0] base, input int n);
      int bad = 0;
      check({tag, "_count"}, wr_q.size(), n);
      for (int i = 0; i < n && i < wr_q.size(); i++) begin
         if (wr_q[i] !== base + 16'(i)) bad++;
      end
      check({tag, "_bad_words"}, bad, 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check(tag, {job_accept, config_mode, wht_config_wren, job_busy, job_done, wht_in_ready,
                  wht_config_data}, 0);
   endtask

   initial begin
      rst = 1'b1; job_start = 1'b0; num_kernels = 4'd0; abort = 1'b0;
      wht_in_valid = 1'b0; wht_in_data = 16'h0;
      clr_stats();
      ticks(2);
      check_idle_outputs("reset_outputs");
      rst = 1'b0;
      tick();

      // Single kernel, no stalls.
      clr_stats();
      start_job(4'd0, 1'b0);
      feed(9, 16'h0001, 1'b0, -1);
      ticks(6);
      check("t1_accept_cyc", acc_cyc, t0 + 1);
      check("t1_first_wr", first_wr, t0 + 3);
      check("t1_last_wr", last_wr, t0 + 11);
      check_data("t1_data", 16'h0001, 9);
      check("t1_done_cyc", done_cyc, t0 + 12);
      check("t1_done_cnt", n_done, 1);
      check("t1_cm_first", cm_first, t0 + 1);
      check("t1_cm_last", cm_last, t0 + 11);
      check("t1_cm_cnt", n_cm, 11);
      check("t1_busy_last", busy_last, t0 + 12);

      // Backpressure, two kernels.
      clr_stats();
      start_job(4'd1, 1'b0);
      feed(18, 16'h0100, 1'b1, -1);
      ticks(6);
      check_data("t2_data", 16'h0100, 18);
      check("t2_done_cyc", done_cyc, last_hs + 2);
      check("t2_ready_drop", ready_drop, 0);
      check("t2_done_cnt", n_done, 1);

      // Maximum kernel count.
      clr_stats();
      start_job(4'd15, 1'b0);
      feed(144, 16'h1000, 1'b0, -1);
      ticks(6);
      check_data("t3_data", 16'h1000, 144);
      check("t3_done_cyc", done_cyc, t0 + 147);
      check("t3_done_cnt", n_done, 1);

      // job_start during LOAD must be ignored.
      clr_stats();
      start_job(4'd0, 1'b0);
      feed(9, 16'h2000, 1'b0, t0 + 5);
      ticks(8);
      check("t4_accept_cnt", n_acc, 1);
      check("t4_done_cnt", n_done, 1);
      check("t4_done_cyc", done_cyc, t0 + 12);
      check_data("t4_data", 16'h2000, 9);

      // Abort after 5 handshakes; the word offered with abort is dropped.
      clr_stats();
      start_job(4'd1, 1'b0);
      feed(5, 16'h3000, 1'b0, -1);
      abort = 1'b1; wht_in_valid = 1'b1; wht_in_data = 16'h3fff;
      tick();
      abort = 1'b0; wht_in_valid = 1'b0;
      check("t5_cm_after_abort", config_mode, 1'b0);
      check("t5_rdy_after_abort", wht_in_ready, 1'b0);
      check("t5_busy_after_abort", job_busy, 1'b0);
      ticks(5);
      check("t5_done_cnt", n_done, 0);
      check_data("t5_data", 16'h3000, 5);
      // Restart with abort also high in IDLE: job_start wins.
      clr_stats();
      start_job(4'd0, 1'b1);
      feed(9, 16'h4000, 1'b0, -1);
      ticks(6);
      check_data("t5b_data", 16'h4000, 9);
      check("t5b_done_cyc", done_cyc, t0 + 12);

      // Reset after 3 writes.
      clr_stats();
      start_job(4'd0, 1'b0);
      feed(3, 16'h5000, 1'b0, -1);
      check("t6_pre_writes", wr_q.size(), 3);
      clr_stats();
      rst = 1'b1; wht_in_valid = 1'b1;
      tick();
      check_idle_outputs("t6_reset_outputs");
      ticks(2);
      rst = 1'b0; wht_in_valid = 1'b0;
      check("t6_writes_in_reset", wr_q.size(), 0);
      tick();
      clr_stats();
      start_job(4'd0, 1'b0);
      feed(9, 16'h6000, 1'b0, -1);
      ticks(6);
      check_data("t6_data", 16'h6000, 9);
      check("t6_done_cyc", done_cyc, t0 + 12);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cnn_layer_accel_weight_cfg_loader.md
# cnn_layer_accel_weight_cfg_loader

Streams 3x3 kernel weights from an upstream 16-bit valid/ready source into the CE weight table's configuration port. It produces the `job_accept`, `config_mode`, `wht_config_wren` and `wht_config_data` sequence the table needs to fill kernels 0..`num_kernels` in order. It sits between the layer-job controller and each `cnn_layer_accel_weight_table_top` instance, and it runs entirely in the `clk_core` domain.

## Interface
- `C_KERNEL_WORDS`, default 9: weight words per 3x3 kernel. It equals the table's `KERNEL_3x3_COUNT_FULL_MINUS_1` + 1.
- `C_CLG2_MAX_KERNELS`, default `clog2(MAX_BRAM_3x3_KERNELS)`: width of `num_kernels`.

Ports:
- `clk_core`  in  1  core clock. This is the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `job_start`  in  1  single-cycle request to load one weight set. It is honoured only in IDLE.
- `num_kernels`  in  `C_CLG2_MAX_KERNELS`  index of the last kernel (kernel count − 1). It is sampled in the cycle `job_start` is accepted.
- `abort`  in  1  cancels a load in progress.
- `wht_in_valid`  in  1  an upstream weight word is present.
- `wht_in_data`  in  16  upstream weight word.
- `wht_in_ready`  out  1  the loader accepts a word. It is high only in LOAD and never depends on `wht_in_valid`.
- `job_accept`  out  1  one-cycle pulse that clears the table's kernel counters.
- `config_mode`  out  1  the table is in configuration mode.
- `wht_config_wren`  out  1  write strobe to the table.
- `wht_config_data`  out  16  write data to the table.
- `job_busy`  out  1  high from ACCEPT through DONE.
- `job_done`  out  1  one-cycle pulse when the final word has been written.

## Operation
- The FSM has five states: IDLE, ACCEPT, LOAD, DRAIN, DONE. All outputs except `wht_in_ready` are registered.
- **IDLE**
  - `job_start` causes: capture `num_kernels` into `last_k`, clear `word_cnt` and `kern_cnt`, go to ACCEPT.
  - `job_start` in any other state is ignored.
- **ACCEPT** (one cycle)
  - Outputs: `job_accept`=1, `config_mode`=1, `job_busy`=1.
  - Next state: LOAD.
- **LOAD**
  - Outputs: `wht_in_ready`=1.
  - Each handshake (`wht_in_valid` && `wht_in_ready`) causes:
    - `wht_config_data` ← `wht_in_data`, and `wht_config_wren`=1 in the next cycle. With no handshake, `wht_config_wren`=0 and `wht_config_data` holds its value.
    - `word_cnt` increments. It wraps to 0 at `C_KERNEL_WORDS`−1, and on that wrap `kern_cnt` increments.
  - On the handshake where `word_cnt`==`C_KERNEL_WORDS`−1 and `kern_cnt`==`last_k`: go to DRAIN.
- **DRAIN** (one cycle)
  - Outputs: `wht_in_ready`=0, `config_mode` still 1, `wht_config_wren`=1 for the last word.
  - This keeps `config_mode` high while the table sees its final kernel-increment write.
- **DONE** (one cycle)
  - Outputs: `config_mode`=0, `wht_config_wren`=0, `job_done`=1.
  - Next state: IDLE. `job_busy` drops on entering IDLE.
- **abort**
  - In any non-IDLE state: next state is IDLE.
  - `config_mode`, `wht_config_wren`, `job_busy` and `wht_in_ready` go to 0 next cycle. A pending write is suppressed and no `job_done` is issued.
  - `abort` in IDLE has no effect.
  - `abort` and `job_start` together in IDLE: `job_start` wins.
- **Counter widths**
  - `word_cnt` is `clog2(C_KERNEL_WORDS)` bits.
  - `kern_cnt` is `C_CLG2_MAX_KERNELS` bits and never exceeds `last_k`, so there is no overflow.
- **Reset**
  - All outputs are 0, including `wht_config_data`=16'h0000. The state is IDLE and the counters are 0.
  - Reset mid-load behaves exactly like power-on.

## Timing
- Cycle t0: `job_start` sampled in IDLE.
- t0+1: ACCEPT. `job_accept`, `config_mode` and `job_busy` are high.
- t0+2: first cycle with `wht_in_ready`=1.
- Write latency: a handshake in cycle t produces `wht_config_wren` in cycle t+1. Throughput is one word per cycle.
- Last handshake at cycle tL:
  - tL+1: DRAIN, carrying the final write.
  - tL+2: `job_done`=1, `config_mode`=0.
  - tL+3: IDLE, `job_busy`=0, and a new `job_start` is accepted.
- Unstalled run: W = (`num_kernels`+1)·`C_KERNEL_WORDS` words.
  - `job_done` arrives at t0+W+3 and the table sees exactly W writes.
  - Minimum job-to-job spacing is W+4 cycles.
- Backpressure: `wht_in_valid` may drop in any cycle. The loader waits indefinitely and has no timeout.

## Test plan
- **Single kernel, no stalls:** `num_kernels`=0, data 0x0001..0x0009 presented back to back → `job_accept` at t0+1; 9 consecutive `wht_config_wren` cycles at t0+3..t0+11 with data 0x0001..0x0009; `job_done` at t0+12; `config_mode` high t0+1..t0+11.
- **Backpressure:** `num_kernels`=1, `wht_in_valid` toggling 1,0,1,0 → exactly 18 writes in input order; `job_done` 2 cycles after the 18th handshake; `wht_in_ready` never drops during LOAD.
- **Maximum kernels:** `num_kernels`=`MAX_BRAM_3x3_KERNELS`−1 with an incrementing pattern → `MAX_BRAM_3x3_KERNELS`·9 writes; `kern_cnt` wraps only after `job_done`; a scoreboard matches every word.
- **Start while busy:** `job_start` pulsed at t0+5 during LOAD → ignored; no second `job_accept`; `job_done` fires exactly once.
- **Abort mid-load:** `abort` after 5 handshakes → `config_mode`, `wht_in_ready` and `job_busy` are 0 next cycle; no `job_done`; a following `job_start` with `num_kernels`=0 completes normally with 9 writes.
- **Reset mid-load:** `rst` asserted after 3 writes → all outputs 0 in the cycle after reset; no writes while reset is held; a clean job runs after release.
